tile_router_ingress_buffer: RTL and testbench

- Elastic FIFO placed directly upstream of each tile router input. One instance per router input lane.
- Decouples the producer (link or local engine) from router arbitration stalls; absorbs bursts up to C_DEPTH packets.
- Exposes fill level, almost-full and an accepted-packet counter for link flow control and debug.
- Payload is opaque: 66-bit router packet, never modified or inspected.

---
 rtl/tile_router_defines.sv | 34 +++
 rtl/tile_router_fifo_mem.sv | 36 +++
 rtl/tile_router_ingress_buffer.sv | 112 +++++++++++
 tb/tb_tile_router_ingress_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tile_router_defines.sv
`default_nettype none
// ============================================================================
// Module      : tile_router_defines (package)
// Description : Shared constants and helpers for the tile router ingress path:
//               default packet width, default buffer depth and almost-full
//               threshold, and a constant-foldable ceiling log2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_router_defines;

   // Router packet width in bits. The payload is opaque to the ingress buffer.
   localparam int C_PACKET_WIDTH_DEFAULT       = 66;

   // Default ingress buffer depth in packets. Must be a power of two.
   localparam int C_DEPTH_DEFAULT              = 8;

   // Default fill level at which almost_full is raised toward the link.
   localparam int C_ALMOST_FULL_THRESH_DEFAULT = 6;

   // Ceiling log2. Returns the number of address bits needed to index
   // 'value' entries, with clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : tile_router_defines
`default_nettype wire

// File: rtl/tile_router_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : tile_router_fifo_mem
// Description : Simple dual-port packet storage for the ingress buffer. One
//               synchronous write port, one asynchronous read port. Written
//               as a plain array so it maps onto distributed RAM. Contents are
//               never reset; validity is tracked by the parent's pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_router_fifo_mem #(
   parameter int C_PACKET_WIDTH = 66,
   parameter int C_DEPTH        = 8,
   parameter int C_ADDR_WIDTH   = 3
) (
   input  logic                      clk,
   input  logic                      wr_en,
   input  logic [C_ADDR_WIDTH-1:0]   wr_addr,
   input  logic [C_PACKET_WIDTH-1:0] wr_data,
   input  logic [C_ADDR_WIDTH-1:0]   rd_addr,
   output logic [C_PACKET_WIDTH-1:0] rd_data
);

   logic [C_PACKET_WIDTH-1:0] r_mem [C_DEPTH];

   // Write one packet per cycle; no reset so the array stays RAM-inferable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read: the head packet is visible as soon as rd_addr settles.
   assign rd_data = r_mem[rd_addr];

endmodule : tile_router_fifo_mem
`default_nettype wire

// File: rtl/tile_router_ingress_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tile_router_ingress_buffer
// Description : Elastic FIFO in front of one tile router input lane. Absorbs
//               producer bursts while the router arbitrates, reports fill
//               level / almost-full for link flow control and counts every
//               accepted packet. Payload passes through untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_router_ingress_buffer
   import tile_router_defines::*;
#(
   parameter  int C_PACKET_WIDTH       = C_PACKET_WIDTH_DEFAULT,
   parameter  int C_DEPTH              = C_DEPTH_DEFAULT,
   parameter  int C_ALMOST_FULL_THRESH = C_ALMOST_FULL_THRESH_DEFAULT,
   localparam int C_LOG2_DEPTH         = clog2(C_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   // Producer side
   input  logic                      in_valid,
   output logic                      in_accept,
   input  logic [C_PACKET_WIDTH-1:0] in_payload,
   // Router side
   output logic                      out_valid,
   input  logic                      out_accept,
   output logic [C_PACKET_WIDTH-1:0] out_payload,
   // Status
   output logic [C_LOG2_DEPTH:0]     fill_level,
   output logic                      almost_full,
   output logic [31:0]               pkt_count
);

   localparam logic [C_LOG2_DEPTH:0] c_full_level = (C_LOG2_DEPTH+1)'(C_DEPTH);
   localparam logic [C_LOG2_DEPTH:0] c_af_level   = (C_LOG2_DEPTH+1)'(C_ALMOST_FULL_THRESH);

   logic [C_LOG2_DEPTH-1:0] r_wr_ptr;
   logic [C_LOG2_DEPTH-1:0] r_rd_ptr;
   logic [C_LOG2_DEPTH:0]   r_fill_level;
   logic [31:0]             r_pkt_count;

   logic                    w_push;
   logic                    w_pop;

   // Handshake is derived only from registered state (plus rst), so there is
   // no combinational path from out_accept to in_accept. When full, a pop in
   // the same cycle does not open a slot until the following cycle.
   assign in_accept = (r_fill_level != c_full_level) & ~rst;
   assign out_valid = (r_fill_level != '0);

   // in_accept already masks rst; the pop is masked explicitly so that a
   // transfer coincident with reset changes nothing.
   assign w_push = in_valid & in_accept;
   assign w_pop  = out_valid & out_accept & ~rst;

   // Write and read pointers; the depth is a power of two so they wrap
   // naturally from DEPTH-1 back to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy: +1 on push only, -1 on pop only, unchanged when both happen.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill_level <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_fill_level <= r_fill_level + 1'b1;
            2'b01:   r_fill_level <= r_fill_level - 1'b1;
            default: r_fill_level <= r_fill_level;
         endcase
      end
   end

   // Accepted-packet counter for debug; wraps modulo 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt_count <= '0;
      end else if (w_push) begin
         r_pkt_count <= r_pkt_count + 32'd1;
      end
   end

   tile_router_fifo_mem #(
      .C_PACKET_WIDTH (C_PACKET_WIDTH),
      .C_DEPTH        (C_DEPTH),
      .C_ADDR_WIDTH   (C_LOG2_DEPTH)
   ) u_fifo_mem (
      .clk     (clk),
      .wr_en   (w_push),
      .wr_addr (r_wr_ptr),
      .wr_data (in_payload),
      .rd_addr (r_rd_ptr),
      .rd_data (out_payload)
   );

   assign fill_level  = r_fill_level;
   assign almost_full = (r_fill_level >= c_af_level);
   assign pkt_count   = r_pkt_count;

endmodule : tile_router_ingress_buffer
`default_nettype wire

// File: tb/tb_tile_router_ingress_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_router_ingress_buffer
// Description : Self-checking bench for the ingress buffer. A driver applies
//               directed and random traffic and keeps a queue-based model of
//               the buffer; expected packets go into a scoreboard queue that
//               an independent output monitor consumes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_router_ingress_buffer;

   localparam int PW     = 66;
   localparam int DEPTH  = 8;
   localparam int THRESH = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_accept;
   logic [PW-1:0] in_payload = '0;
   logic          out_valid;
   logic          out_accept = 1'b0;
   logic [PW-1:0] out_payload;
   logic [3:0]    fill_level;
   logic          almost_full;
   logic [31:0]   pkt_count;

   tile_router_ingress_buffer #(
      .C_PACKET_WIDTH       (PW),
      .C_DEPTH              (DEPTH),
      .C_ALMOST_FULL_THRESH (THRESH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_accept   (in_accept),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_accept  (out_accept),
      .out_payload (out_payload),
      .fill_level  (fill_level),
      .almost_full (almost_full),
      .pkt_count   (pkt_count)
   );

   always #5 clk = ~clk;

   int            vectors = 0;
   int            errors  = 0;
   bit            run     = 1'b0;

   // Reference model: occupancy and counter as plain integers, contents as a queue.
   int            m_fill = 0;
   logic [31:0]   m_pkt  = '0;
   logic [PW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus. Status outputs are checked against the model just
   // after the edge, then the new inputs are applied and the model advanced to
   // the state expected after the next edge.
   task automatic drive(input logic r, input logic v, input logic [PW-1:0] p, input logic a);
      bit push;
      bit pop;
      @(posedge clk);
      #1;
      chk("fill_level",  PW'(fill_level),  PW'(m_fill));
      chk("out_valid",   PW'(out_valid),   PW'(m_fill != 0));
      chk("almost_full", PW'(almost_full), PW'(m_fill >= THRESH));
      chk("pkt_count",   PW'(pkt_count),   PW'(m_pkt));
      rst        = r;
      in_valid   = v;
      in_payload = p;
      out_accept = a;
      #1;
      chk("in_accept", PW'(in_accept), PW'(!r && (m_fill != DEPTH)));
      push = !r && v && (m_fill != DEPTH);
      pop  = !r && a && (m_fill != 0);
      if (r) begin
         m_fill = 0;
         m_pkt  = '0;
      end else begin
         if (push) begin
            exp_q.push_back(p);
            m_pkt = m_pkt + 32'd1;
         end
         m_fill = m_fill + int'(push) - int'(pop);
      end
   endtask

   function automatic logic [PW-1:0] rnd_payload();
      logic [95:0] w;
      w = {$urandom, $urandom, $urandom};
      return w[PW-1:0];
   endfunction

   // Output monitor: the head packet must match the oldest expected packet
   // whenever valid, and must not change while stalled.
   logic          prev_stall = 1'b0;
   logic [PW-1:0] prev_payload = '0;
   always @(negedge clk) begin
      if (run) begin
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL out_payload: got %0h with out_valid=1 expected no packet (t=%0t)", out_payload, $time);
            end else begin
               chk("out_payload", out_payload, exp_q[0]);
               if (!rst && out_accept) begin
                  void'(exp_q.pop_front());
               end
            end
            if (prev_stall) begin
               chk("stall_hold", out_payload, prev_payload);
            end
         end
         if (rst) begin
            exp_q.delete();
         end
         prev_stall   = (out_valid === 1'b1) && !out_accept && !rst;
         prev_payload = out_payload;
      end
   end

   initial begin
      run = 1'b1;

      // Reset held for three cycles with a packet offered.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, PW'(i + 100), 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);

      // Single packet with the router always accepting.
      drive(1'b0, 1'b1, 66'h2_0000_0000_DEAD_BEEF, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);

      // Fill past capacity with the router stalled, then drain.
      for (int i = 1; i <= 10; i++) drive(1'b0, 1'b1, PW'(i), 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, '0, 1'b1);

      // Full buffer seeing push and pop together: pop only, push next cycle.
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, PW'(i + 32'h200), 1'b0);
      drive(1'b0, 1'b1, PW'(32'h300), 1'b1);
      drive(1'b0, 1'b1, PW'(32'h300), 1'b0);
      drive(1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, '0, 1'b1);

      // Streaming: continuous push and pop, pointers wrap many times.
      drive(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, PW'(i + 32'h1000), 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);

      // Random stress in phases with different push/pop bias.
      for (int ph = 0; ph < 10; ph++) begin
         int pv;
         int pa;
         pv = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 30 : 55);
         pa = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 80 : 55);
         for (int i = 0; i < 1000; i++) begin
            drive(1'b0, ($urandom_range(99) < pv), rnd_payload(),
                  ($urandom_range(99) < pa));
         end
      end

      // Reset in the middle of traffic with packets buffered.
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, rnd_payload(), 1'b0);
      drive(1'b1, 1'b1, rnd_payload(), 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b1, rnd_payload(), 1'b1);
      drive(1'b0, 1'b0, '0, 1'b1);
      drive(1'b0, 1'b0, '0, 1'b0);

      @(posedge clk);
      #1;
      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_tile_router_ingress_buffer
`default_nettype wire
